// File: rtl/button_conditioner_if.sv
// Push-button bundle between board pins and the controller: raw pin levels in,
// debounced level and one-cycle press/release/repeat strobes out.
interface button_conditioner_if #(
  parameter int unsigned N_CHAN = 4
);
  logic [N_CHAN-1:0] button_in;
  logic [N_CHAN-1:0] held;
  logic [N_CHAN-1:0] press_pulse;
  logic [N_CHAN-1:0] release_pulse;
  logic [N_CHAN-1:0] repeat_pulse;

  // Pin side drives raw levels and consumes the conditioned outputs
  modport master (
    output button_in,
    input  held,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse
  );

  // Conditioner side
  modport slave (
    input  button_in,
    output held,
    output press_pulse,
    output release_pulse,
    output repeat_pulse
  );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: two-flop synchroniser, stable-time
// debounce, registered press/release strobes and an optional auto-repeat.
// Auto-repeat is built only when BUTTON_CONDITIONER_AUTOREPEAT_EN is defined;
// otherwise repeat_pulse is tied low and the repeat parameters are unused.
module button_conditioner #(
  parameter int unsigned N_CHAN          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  button_conditioner_if.slave  btn
);

  localparam int unsigned     DB_W         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic            RELEASED_PIN = ACTIVE_LOW;

  // Reject parameter sets the datapath cannot represent
  if (N_CHAN < 1 || N_CHAN > 32 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_conditioner: parameter out of range");
  end

  logic [N_CHAN-1:0] sync_1;
  logic [N_CHAN-1:0] sync_2;
  logic [N_CHAN-1:0] level_s;
  logic [N_CHAN-1:0] held_r;
  logic [N_CHAN-1:0] held_q;
  logic [N_CHAN-1:0] press_r;
  logic [N_CHAN-1:0] release_r;
  logic [N_CHAN-1:0] press_c;
  logic [N_CHAN-1:0] release_c;

  // Two-flop synchroniser; resets to the released pin level so reset release
  // never looks like a press
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= {N_CHAN{RELEASED_PIN}};
      sync_2 <= {N_CHAN{RELEASED_PIN}};
    end else begin
      sync_1 <= btn.button_in;
      sync_2 <= sync_1;
    end
  end

  // Normalised level, 1 = pressed
  assign level_s = ACTIVE_LOW ? ~sync_2 : sync_2;

  for (genvar i = 0; i < int'(N_CHAN); i++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic            held_b;

    // Stable-time debounce: any return to the held level restarts the count
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt    <= '0;
        held_b <= 1'b0;
      end else if (level_s[i] == held_b) begin
        cnt    <= '0;
      end else if (cnt == DB_LAST) begin
        cnt    <= '0;
        held_b <= ~held_b;
      end else begin
        cnt    <= cnt + DB_W'(1);
      end
    end

    assign held_r[i] = held_b;
  end

  // Edge detect on the debounced level; the _c terms lead the strobes by one
  // cycle so the repeat FSM can react on the same edge the strobe registers
  assign press_c   =  held_r & ~held_q;
  assign release_c = ~held_r &  held_q;

  // Registered press/release strobes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held_q    <= '0;
      press_r   <= '0;
      release_r <= '0;
    end else begin
      held_q    <= held_r;
      press_r   <= press_c;
      release_r <= release_c;
    end
  end

  assign btn.held          = held_r;
  assign btn.press_pulse   = press_r;
  assign btn.release_pulse = release_r;

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = ($clog2(RPT_MAX) < 1) ? 1 : $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] RPT_LOAD_DELAY  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_LOAD_PERIOD = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  logic [N_CHAN-1:0] repeat_r;

  for (genvar i = 0; i < int'(N_CHAN); i++) begin : g_rpt
    rpt_state_e       state_r;
    rpt_state_e       state_n;
    logic [RPT_W-1:0] cnt_r;
    logic [RPT_W-1:0] cnt_n;
    logic             rpt_r;
    logic             rpt_n;

    // Repeat state, counter and strobe registers
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_r <= RPT_IDLE;
        cnt_r   <= '0;
        rpt_r   <= 1'b0;
      end else begin
        state_r <= state_n;
        cnt_r   <= cnt_n;
        rpt_r   <= rpt_n;
      end
    end

    // Delay then periodic ticks while held; release beats a same-cycle expiry
    always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      rpt_n   = 1'b0;
      case (state_r)
        RPT_IDLE: begin
          if (press_c[i]) begin
            state_n = RPT_DELAY;
            cnt_n   = RPT_LOAD_DELAY;
          end
        end
        RPT_DELAY, RPT_REPEAT: begin
          if (release_c[i]) begin
            state_n = RPT_IDLE;
            cnt_n   = '0;
          end else if (cnt_r == '0) begin
            state_n = RPT_REPEAT;
            cnt_n   = RPT_LOAD_PERIOD;
            rpt_n   = 1'b1;
          end else begin
            cnt_n   = cnt_r - RPT_W'(1);
          end
        end
        default: begin
          state_n = RPT_IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    assign repeat_r[i] = rpt_r;
  end

  assign btn.repeat_pulse = repeat_r;
`else
  assign btn.repeat_pulse = '0;
`endif

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Multi-channel push-button front end replacing the single-input debounce-and-edge logic in the top level. Each channel synchronises a raw pin, debounces it with a stable-time counter and emits one-cycle press and release strobes. Optionally, each channel emits an auto-repeat strobe while the key is held. Sits between the board pins and the controller; one instance serves a keypad row, the reset button and any mode keys.

## Interface
Parameters:
- `N_CHAN`, 4: number of independent channels (1..32).
- `DEBOUNCE_CYCLES`, 1000000: cycles the synchronised input must hold a new level before it is accepted (≥1; 20 ms at 50 MHz).
- `ACTIVE_LOW`, 1: 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- `REPEAT_DELAY`, 25000000: cycles from press strobe to first repeat strobe (≥1).
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat strobes (≥1).

Ports:
- `clock`  in  1  system clock (CLOCK_50 at top).
- `reset_n`  in  1  asynchronous, active-low reset.
- `button_in`  in  N_CHAN  raw, asynchronous pin levels.
- `held`  out  N_CHAN  debounced level, 1 = pressed.
- `press_pulse`  out  N_CHAN  one-cycle strobe on accepted press.
- `release_pulse`  out  N_CHAN  one-cycle strobe on accepted release.
- `repeat_pulse`  out  N_CHAN  one-cycle strobe per auto-repeat tick.

## Operation
- All channels are independent and identical. Any combination of strobes on different channels may be asserted in the same cycle.
- **Synchroniser:** two flops per channel. `ACTIVE_LOW` inversion is applied after the synchroniser, giving a normalised level `s` with 1 = pressed.
- **Debounce:**
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - While `s == held`, the counter is cleared.
  - While `s != held`, the counter increments.
  - On the cycle the counter equals `DEBOUNCE_CYCLES-1` with `s` still different, `held` toggles and the counter clears.
  - Any glitch returning `s` to `held` before that point clears the counter. There is no partial credit.
- **Strobes:** `press_pulse = held & ~held_q` and `release_pulse = ~held & held_q`, both registered. Each is exactly one cycle.
- **Repeat FSM (per channel, 3 states):**
  - IDLE → DELAY on the cycle `press_pulse` is asserted; repeat counter loads `REPEAT_DELAY-1`.
  - DELAY: counter decrements. At 0, assert `repeat_pulse`, load `REPEAT_PERIOD-1` and go to REPEAT.
  - REPEAT: counter decrements. At 0, assert `repeat_pulse` and reload `REPEAT_PERIOD-1`.
  - DELAY or REPEAT → IDLE on the cycle `release_pulse` is asserted. If the counter expires in that same cycle, no `repeat_pulse` is issued; release wins.
  - Counter width is `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD))`, minimum 1.
- Bounce shorter than `DEBOUNCE_CYCLES` during a hold does not disturb `held` or the repeat cadence.

## Timing
- **Reset (async assert, sync release):**
  - `held`, `press_pulse`, `release_pulse` and `repeat_pulse` are all 0.
  - Synchroniser flops are set to the released level.
  - Counters are 0 and the FSM is in IDLE.
- A key held through reset release is reported as a fresh press after full debounce.
- Reset asserted mid-debounce or mid-repeat aborts immediately. No strobe is emitted for the aborted event.
- **Press latency:** a clean level change first sampled at edge k gives `held` = 1 after edge k+1+`DEBOUNCE_CYCLES`. `press_pulse` is high for the following cycle.
- Release latency is identical to press latency.
- First `repeat_pulse` comes `REPEAT_DELAY` cycles after `press_pulse`. Later pulses are spaced exactly `REPEAT_PERIOD` cycles apart.
- Minimum accepted pulse width is `DEBOUNCE_CYCLES` cycles of synchronised level.

## Configuration
- Macro `BUTTON_CONDITIONER_AUTOREPEAT_EN`.
- **Defined:** the repeat FSM and counters are built as described above.
- **Undefined:** no repeat logic is synthesised, `repeat_pulse` is tied to 0, and `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.
- Debounce and edge behaviour are identical in both builds.

## Test plan
Bench parameters: `N_CHAN`=4, `DEBOUNCE_CYCLES`=8, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5, `ACTIVE_LOW`=1.

- **Clean press:** `button_in[0]` 1→0 at edge k and held → `held[0]`=1 after edge k+9, then `press_pulse[0]` high for exactly one cycle. Other channels stay 0.
- **Bounce rejection:** `button_in[1]` toggles low for 5 cycles, high for 2, then low for 7, ending high → no strobes and `held[1]` stays 0. Then hold low for 12 cycles → one `press_pulse[1]`.
- **Auto-repeat (macro defined):** hold ch2 for 60 cycles after `press_pulse` → `repeat_pulse[2]` at +20, +25, ... , +55 (8 pulses). Release → one `release_pulse[2]` and no further repeats.
- **Macro undefined:** same stimulus as the auto-repeat case → `repeat_pulse` stays 0 throughout. Press and release strobes are unchanged.
- **Simultaneous keys:** ch0 and ch3 pressed on the same edge → both `press_pulse` bits asserted in the same cycle.
- **Reset mid-operation:**
  - Assert `reset_n`=0 during ch2 REPEAT → all outputs are 0 within the same cycle, asynchronously.
  - Release reset with the key still held → a fresh `press_pulse[2]` 9+1 cycles later.
  - First repeat follows 20 cycles after that press.
